// File: rtl/alu_unit_if.sv
// Operand/result bundle between the execute-stage operand muxes and the ALU.
// The master drives the operation and operands; the slave returns result and flags.
interface alu_unit_if #(
    parameter int Width = 8
);
    logic [3:0]       ctrlSig;
    logic [Width-1:0] op1;
    logic [Width-1:0] op2;
    logic [Width-1:0] aluOut;
    logic             zero;
    logic             carry;

    modport master (
        output ctrlSig, op1, op2,
        input  aluOut, zero, carry
    );

    modport slave (
        input  ctrlSig, op1, op2,
        output aluOut, zero, carry
    );
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU: eleven arithmetic/logic/shift/compare/pass operations,
// result and carry captured each clock, zero derived from the result register.
module alu_unit #(
    parameter int Width = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_unit_if.slave  bus
);
    localparam int ShW = $clog2(Width);

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpSll   = 4'd5,
        OpSrl   = 4'd6,
        OpSra   = 4'd7,
        OpSlt   = 4'd8,
        OpSltu  = 4'd9,
        OpPassB = 4'd10
    } op_e;

    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic [ShW-1:0]   sh;
    logic [Width:0]   sum;
    logic [Width:0]   diff;
    logic [Width-1:0] sraVal;
    logic [Width-1:0] nextOut;
    logic             nextCarry;
    logic [Width-1:0] outReg;
    logic             carryReg;

    assign a  = bus.op1;
    assign b  = bus.op2;
    assign sh = bus.op2[ShW-1:0];

    // Width+1 bit arithmetic: the top bit of the difference is the unsigned borrow.
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign sraVal = $signed(a) >>> sh;

    always_comb begin
        nextOut   = '0;
        nextCarry = 1'b0;
        case (bus.ctrlSig)
            OpAdd: begin
                nextOut   = sum[Width-1:0];
                nextCarry = sum[Width];
            end
            OpSub: begin
                nextOut   = diff[Width-1:0];
                nextCarry = diff[Width];
            end
            OpAnd:   nextOut = a & b;
            OpOr:    nextOut = a | b;
            OpXor:   nextOut = a ^ b;
            OpSll:   nextOut = a << sh;
            OpSrl:   nextOut = a >> sh;
            OpSra:   nextOut = sraVal;
            OpSlt:   nextOut = {{(Width-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu:  nextOut = {{(Width-1){1'b0}}, (a < b)};
            OpPassB: nextOut = b;
            default: begin
                nextOut   = '0;
                nextCarry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outReg   <= '0;
            carryReg <= 1'b0;
        end else begin
            outReg   <= nextOut;
            carryReg <= nextCarry;
        end
    end

    assign bus.aluOut = outReg;
    assign bus.carry  = carryReg;
    assign bus.zero   = (outReg == '0);
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit (Width = 8): directed literal checks plus an
// integer-arithmetic reference model compared against the outputs every cycle.
module tb_alu_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] expOut   = 8'd0;
    logic       expCarry = 1'b0;

    alu_unit_if #(.Width(8)) bus ();

    alu_unit #(.Width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operation rules, returns {carry, result}.
    function automatic logic [8:0] modelAlu(input int code, input int a, input int b);
        int r;
        int sh;
        int sa;
        int sb;
        logic c;
        r  = 0;
        c  = 1'b0;
        sh = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (code)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b);   end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * (2 ** sh);
            6: r = a / (2 ** sh);
            7: r = sa >>> sh;
            8: r = (sa < sb) ? 1 : 0;
            9: r = (a < b) ? 1 : 0;
            10: r = b;
            default: begin r = 0; c = 1'b0; end
        endcase
        return {c, r[7:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expOut   <= 8'd0;
            expCarry <= 1'b0;
        end else begin
            {expCarry, expOut} <= modelAlu(int'(bus.ctrlSig), int'(bus.op1), int'(bus.op2));
        end
    end

    task automatic applyStimulus(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b);
        bus.ctrlSig = code;
        bus.op1     = a;
        bus.op2     = b;
    endtask

    // Advance to the next falling edge and compare the outputs with the model.
    task automatic tick();
        @(negedge clk);
        compared++;
        if (bus.aluOut !== expOut || bus.carry !== expCarry || bus.zero !== (expOut == 8'd0)) begin
            mismatched++;
            $display("[TB] FAIL model t=%0t got out=%0d carry=%0b zero=%0b required out=%0d carry=%0b zero=%0b",
                     $time, bus.aluOut, bus.carry, bus.zero, expOut, expCarry, (expOut == 8'd0));
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eOut, input logic eCarry, input logic eZero);
        compared++;
        if (bus.aluOut !== eOut || bus.carry !== eCarry || bus.zero !== eZero) begin
            mismatched++;
            $display("[TB] FAIL %s got out=%0d carry=%0b zero=%0b required out=%0d carry=%0b zero=%0b",
                     name, bus.aluOut, bus.carry, bus.zero, eOut, eCarry, eZero);
        end
    endtask

    logic [7:0] sweepExp [0:10];
    logic [7:0] rsvCode;

    initial begin
        sweepExp = '{8'd14, 8'd6, 8'd0, 8'd14, 8'd14, 8'd160, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4};

        // Held in reset with non-zero inputs.
        applyStimulus(4'd0, 8'hFF, 8'hFF);
        tick();
        tick();
        checkOutput("reset_hold", 8'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // Sweep codes 0..10 with A=10, B=4, one code per cycle.
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(i[3:0], 8'd10, 8'd4);
            tick();
            checkOutput($sformatf("sweep_code%0d", i), sweepExp[i], 1'b0, (sweepExp[i] == 8'd0));
        end

        applyStimulus(4'd0, 8'd255, 8'd1);
        tick();
        checkOutput("add_255_1", 8'd0, 1'b1, 1'b1);
        applyStimulus(4'd1, 8'd4, 8'd10);
        tick();
        checkOutput("sub_4_10", 8'd250, 1'b1, 1'b0);
        applyStimulus(4'd1, 8'd10, 8'd10);
        tick();
        checkOutput("sub_10_10", 8'd0, 1'b0, 1'b1);

        applyStimulus(4'd8, 8'h80, 8'h01);
        tick();
        checkOutput("slt_80_01", 8'd1, 1'b0, 1'b0);
        applyStimulus(4'd9, 8'h80, 8'h01);
        tick();
        checkOutput("sltu_80_01", 8'd0, 1'b0, 1'b1);
        applyStimulus(4'd7, 8'h80, 8'h03);
        tick();
        checkOutput("sra_80_3", 8'hF0, 1'b0, 1'b0);
        applyStimulus(4'd6, 8'h80, 8'h03);
        tick();
        checkOutput("srl_80_3", 8'h10, 1'b0, 1'b0);
        applyStimulus(4'd5, 8'h80, 8'h09);
        tick();
        checkOutput("sll_80_9", 8'h00, 1'b0, 1'b1);
        applyStimulus(4'd5, 8'h81, 8'h08);
        tick();
        checkOutput("sll_by_0", 8'h81, 1'b0, 1'b0);

        // Reserved codes must produce zero result and no carry.
        for (int c = 11; c <= 15; c++) begin
            rsvCode = c[7:0];
            applyStimulus(rsvCode[3:0], 8'hFF, 8'hFF);
            tick();
            checkOutput($sformatf("reserved_%0d", c), 8'd0, 1'b0, 1'b1);
        end

        // Back-to-back random vectors, checked against the model every cycle.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
        end

        // Asynchronous clear between clock edges.
        applyStimulus(4'd0, 8'd10, 8'd4);
        @(posedge clk);
        #1;
        checkOutput("pre_async", 8'd14, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear", 8'd0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        applyStimulus(4'd4, 8'hA5, 8'h0F);
        tick();
        checkOutput("after_release", 8'hAA, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
